// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one grant per cycle, registered broadcast.
// Optional round-robin with starvation priority under TOMASULO_CDB_RR_EN.
module cdb_arbiter #(
  parameter int NREQ       = 3,
  parameter int TAG_W      = 3,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*TAG_W-1:0]  req_tag,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   flush,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [DATA_W-1:0]      cdb_data,
  output logic [1:0]             cdb_src,
  output logic [NREQ-1:0]        starve
);

  logic [1:0] ptr;
  logic [1:0] sel;
  logic       hit;
  logic       take;
  logic [2:0] s;
  logic [2:0] cnt [NREQ];

  assign take = hit & ~flush & rst_n;

  // Starve flag is a decode of the registered wait counter
  always_comb begin
    starve = '0;
    for (int i = 0; i < NREQ; i++)
      starve[i] = (cnt[i] == 3'(STARVE_LIM));
  end

  // Pick grantee: starved requesters first (RR only), then any valid
  always_comb begin
    hit = 1'b0;
    sel = '0;
    s   = '0;
`ifdef TOMASULO_CDB_RR_EN
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + 3'(k);
      if (s >= 3'(NREQ)) s = s - 3'(NREQ);
      if (!hit && req_valid[s[1:0]] && starve[s[1:0]]) begin
        hit = 1'b1;
        sel = s[1:0];
      end
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + 3'(k);
      if (s >= 3'(NREQ)) s = s - 3'(NREQ);
      if (!hit && req_valid[s[1:0]]) begin
        hit = 1'b1;
        sel = s[1:0];
      end
    end
  end

  // One-hot grant, suppressed during flush and reset
  always_comb begin
    req_ready = '0;
    if (take) req_ready[sel] = 1'b1;
  end

`ifdef TOMASULO_CDB_RR_EN
  logic [2:0] nxt;

  // Pointer moves just past the grantee
  always_comb begin
    nxt = {1'b0, sel} + 3'd1;
    if (nxt >= 3'(NREQ)) nxt = '0;
  end

  // Round-robin pointer register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)    ptr <= '0;
    else if (take) ptr <= nxt[1:0];
  end
`else
  assign ptr = '0;
`endif

  // Registered broadcast; payload holds when idle
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (take) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= req_tag[int'(sel)*TAG_W +: TAG_W];
      cdb_data  <= req_data[int'(sel)*DATA_W +: DATA_W];
      cdb_src   <= sel;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

  // Saturating wait counters; cleared by grant, idle or flush
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (flush || !req_valid[i] || req_ready[i])
          cnt[i] <= '0;
        else if (cnt[i] < 3'(STARVE_LIM))
          cnt[i] <= cnt[i] + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter.
// Expectations follow TOMASULO_CDB_RR_EN when it is defined.
module tb_cdb_arbiter;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [8:0]  req_tag;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        flush;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [1:0]  cdb_src;
  logic [2:0]  starve;

  int n_cmp = 0;
  int n_err = 0;

  cdb_arbiter dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .starve    (starve)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_g;
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_tag   = '0;
    req_data  = '0;
    flush     = 1'b0;
    #2;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
    chk("rst_starve", 32'(starve), 32'h0);
    tick();
    chk("rst_hold_ready", 32'(req_ready), 32'h0);
    chk("rst_hold_valid", 32'(cdb_valid), 32'h0);

    // single request on requester 1
    @(negedge clk1);
    rst_n = 1'b1;
    req_valid = 3'b010;
    req_tag[3 +: 3] = 3'd5;
    req_data[16 +: 16] = 16'h00A5;
    #1;
    chk("single_ready", 32'(req_ready), 32'h2);
    tick();
    chk("single_valid", 32'(cdb_valid), 32'h1);
    chk("single_tag", 32'(cdb_tag), 32'h5);
    chk("single_data", 32'(cdb_data), 32'h00A5);
    chk("single_src", 32'(cdb_src), 32'h1);

    // rotation from ptr=0
    reset_pulse();
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      req_tag[i*3 +: 3] = 3'(i + 1);
      req_data[i*16 +: 16] = 16'(16'h100 + i);
    end
    for (int k = 0; k < 6; k++) begin
`ifdef TOMASULO_CDB_RR_EN
      exp_g = 3'b001 << (k % 3);
`else
      exp_g = 3'b001;
`endif
      #1;
      chk("rot_ready", 32'(req_ready), 32'(exp_g));
      tick();
      chk("rot_src", 32'(cdb_src), (exp_g == 3'b001) ? 32'd0 :
                                   (exp_g == 3'b010) ? 32'd1 : 32'd2);
      chk("rot_valid", 32'(cdb_valid), 32'h1);
      @(negedge clk1);
    end
`ifdef TOMASULO_CDB_RR_EN
    chk("rot_starve", 32'(starve), 32'h0);
`else
    chk("rot_starve", 32'(starve), 32'h6);
`endif

    // starvation
    reset_pulse();
    req_valid = 3'b011;
`ifdef TOMASULO_CDB_RR_EN
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      @(negedge clk1);
    end
    chk("alt_starve", 32'(starve), 32'h0);
`else
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stv_ready", 32'(req_ready), 32'h1);
      tick();
      if (k == 2) chk("stv_pre", 32'(starve), 32'h0);
      @(negedge clk1);
    end
    chk("stv_set", 32'(starve), 32'h2);
`endif
    req_valid = 3'b010;
    #1;
    chk("stv_grant1", 32'(req_ready), 32'h2);
    tick();
    chk("stv_src", 32'(cdb_src), 32'h1);
    chk("stv_clear", 32'(starve), 32'h0);

    // flush
    reset_pulse();
    req_valid = 3'b010;
    req_tag[3 +: 3] = 3'd6;
    tick();
    chk("fl_pre_valid", 32'(cdb_valid), 32'h1);
    @(negedge clk1);
    req_valid = 3'b101;
    flush = 1'b1;
    #1;
    chk("fl_ready", 32'(req_ready), 32'h0);
    tick();
    chk("fl_cdb_valid", 32'(cdb_valid), 32'h0);
    chk("fl_tag_hold", 32'(cdb_tag), 32'h6);
    @(negedge clk1);
    flush = 1'b0;
    #1;
`ifdef TOMASULO_CDB_RR_EN
    chk("fl_after", 32'(req_ready), 32'h4);
    tick();
    chk("fl_src", 32'(cdb_src), 32'h2);
`else
    chk("fl_after", 32'(req_ready), 32'h1);
    tick();
    chk("fl_src", 32'(cdb_src), 32'h0);
`endif
    chk("fl_valid", 32'(cdb_valid), 32'h1);

    // idle hold
    @(negedge clk1);
    req_valid = 3'b001;
    req_tag[0 +: 3] = 3'd3;
    req_data[0 +: 16] = 16'h1234;
    tick();
    chk("idle_pre_tag", 32'(cdb_tag), 32'h3);
    chk("idle_pre_data", 32'(cdb_data), 32'h1234);
    @(negedge clk1);
    req_valid = 3'b000;
    tick();
    chk("idle_valid", 32'(cdb_valid), 32'h0);
    chk("idle_tag", 32'(cdb_tag), 32'h3);
    chk("idle_data", 32'(cdb_data), 32'h1234);

    // asynchronous reset mid-stream
    @(negedge clk1);
    req_valid = 3'b100;
    req_tag[6 +: 3] = 3'd7;
    req_data[32 +: 16] = 16'hBEEF;
    tick();
    chk("mid_pre_valid", 32'(cdb_valid), 32'h1);
    chk("mid_pre_src", 32'(cdb_src), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(cdb_valid), 32'h0);
    chk("mid_tag", 32'(cdb_tag), 32'h0);
    chk("mid_data", 32'(cdb_data), 32'h0);
    chk("mid_src", 32'(cdb_src), 32'h0);
    chk("mid_ready", 32'(req_ready), 32'h0);
    chk("mid_starve", 32'(starve), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter for the Tomasulo core. It takes result-ready requests from the functional-unit groups (add/sub, mul/div, load queue) and grants one requester per cycle. The granted tag/value pair is broadcast on a registered CDB to the reservation stations, register bank and ROB. It also tracks per-requester wait time and flags starvation.

## Interface
Parameters:
- NREQ, 3, number of requesters (index 0 = add/sub RS, 1 = mul/div RS, 2 = load queue)
- TAG_W, 3, ROB tag width (8-entry ROB)
- DATA_W, 16, result width
- STARVE_LIM, 4, wait cycles at which a requester's starve flag asserts

Ports:
- clk1  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i holds a result
- req_tag  in  NREQ*TAG_W  packed tags; slice i = [i*TAG_W +: TAG_W]
- req_data  in  NREQ*DATA_W  packed results, same packing
- req_ready  out  NREQ  one-hot-or-zero grant (combinational)
- flush  in  1  ROB mispredict flush
- cdb_valid  out  1  broadcast valid (registered)
- cdb_tag  out  TAG_W  broadcast ROB tag (registered)
- cdb_data  out  DATA_W  broadcast value (registered)
- cdb_src  out  2  index of the granted requester (registered)
- starve  out  NREQ  per-requester starvation flag (registered)

## Operation
- Transfer on requester i occurs in a cycle with req_valid[i] & req_ready[i]. The requester holds valid/tag/data stable until it sees ready. It may not drop valid before ready.
- Grant selection: search starts at pointer `ptr` and wraps modulo NREQ. The first i with req_valid[i]=1 gets req_ready[i]=1.
  - Exception: any requester with starve[i]=1 takes precedence. Ties among starved requesters also go by pointer order.
- At most one req_ready bit is high per cycle. It may be high only if req_valid of the same index is high.
- On a grant to i: `ptr <= (i+1) mod NREQ`. With no grant, `ptr` is unchanged.
- The CDB output register loads tag, data and src of the grantee, and sets cdb_valid=1. With no grant, cdb_valid<=0 and tag/data/src hold their previous values.
- Wait counters: per requester, 3-bit, saturating at STARVE_LIM.
  - Increment when req_valid[i]=1 and no grant to i.
  - Clear on a grant to i or when req_valid[i]=0.
  - starve[i] = (count_i == STARVE_LIM).
- Flush:
  - In a cycle with flush=1, req_ready is forced to 0, no transfer occurs, and cdb_valid<=0.
  - ptr is unchanged and all wait counters clear.
  - A broadcast already on the bus in the flush cycle is not retracted; the ROB discards it by tag.
- Reset (rst_n=0, asynchronous):
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, starve=0, ptr=0, counters 0.
  - req_ready=0 while rst_n=0.
  - A reset mid-transfer drops the pending grant; requesters re-request after release.

## Timing
- Grant latency: req_ready is combinational in the same cycle as req_valid.
- Broadcast: cdb_* is valid in cycle N+1 for a transfer in cycle N. The fixed latency is 1 cycle.
- Throughput is one broadcast per cycle. Back-to-back grants to different requesters are allowed.
- The same requester may be granted in consecutive cycles only when no other requester is valid.
- The starve flag asserts on the edge where a requester's wait count reaches STARVE_LIM. It deasserts on the edge after its grant.
- There is no backpressure from CDB consumers; every cdb_valid beat is accepted.

## Configuration
- TOMASULO_CDB_RR_EN defined: round-robin pointer arbitration as above, including starvation priority.
- TOMASULO_CDB_RR_EN undefined: fixed priority, lowest index wins.
  - ptr is removed, i.e. constant 0.
  - Wait counters and starve still operate as status only, and do not alter grant order.

## Test plan
- Reset, single request: with rst_n low, drive req_valid=3'b111 → req_ready=0 and cdb_valid=0. Release reset, then drive only req_valid[1] with tag=5, data=16'h00A5 → req_ready=3'b010 that cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=16'h00A5, cdb_src=1.
- Round-robin rotation: hold req_valid=3'b111 for 6 cycles from ptr=0 → grant sequence 0,1,2,0,1,2, and cdb_src follows one cycle later. Without the macro, the sequence is 0,0,0,0,0,0.
- Starvation (macro off): hold req_valid=3'b011 → requester 1 is never granted and starve[1]=1 after 4 cycles of waiting. Drop valid[0] → requester 1 is granted and starve[1] clears the next cycle.
- Flush: with req_valid=3'b100 pending, pulse flush=1 for one cycle → req_ready=0 and cdb_valid=0 the following cycle. ptr is unchanged, and requester 2 is granted in the cycle after flush.
- Idle hold: after a broadcast of tag=3, data=16'h1234, drive req_valid=0 → cdb_valid=0 while cdb_tag stays 3 and cdb_data stays 16'h1234.
- Reset mid-stream: assert rst_n=0 asynchronously mid-cycle while cdb_valid=1 → all outputs go to 0 immediately, with no clock edge needed.
